// File: rtl/cordic_ctrl.sv
// ============================================================================
// Module   : cordic_ctrl
// Brief    : Sequencer for a 16-iteration rotation-mode CORDIC sin/cos unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cordic_ctrl #(
  parameter logic signed [15:0] ANGLE_MAX = 16'sd25736
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] angle,
  output logic [3:0]         addr,
  output logic               load,
  output logic               inv,
  output logic               busy,
  output logic               done,
  output logic               sin_neg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] C_LAST = 4'd15;

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [16:0] z_q, z_d;
  logic               sin_neg_q, sin_neg_d;

  logic signed [15:0] a_clamp;
  logic signed [16:0] a_ext;
  logic signed [16:0] z_init;
  logic signed [16:0] atan_t;

  // Saturate to [-pi/2, +pi/2]; -32768 lands on the lower bound too.
  always_comb begin
    a_clamp = angle;
    if (angle > ANGLE_MAX) begin
      a_clamp = ANGLE_MAX;
    end else if (angle < -ANGLE_MAX) begin
      a_clamp = -ANGLE_MAX;
    end
  end

  // Fold into [-pi/2, 0]; the sign of sin is restored downstream via sin_neg.
  assign a_ext  = {a_clamp[15], a_clamp};
  assign z_init = a_clamp[15] ? a_ext : -a_ext;

  always_comb begin
    case (cnt_q)
      4'd0:    atan_t = 17'sd12868;
      4'd1:    atan_t = 17'sd7596;
      4'd2:    atan_t = 17'sd4014;
      4'd3:    atan_t = 17'sd2037;
      4'd4:    atan_t = 17'sd1023;
      4'd5:    atan_t = 17'sd512;
      4'd6:    atan_t = 17'sd256;
      4'd7:    atan_t = 17'sd128;
      4'd8:    atan_t = 17'sd64;
      4'd9:    atan_t = 17'sd32;
      4'd10:   atan_t = 17'sd16;
      4'd11:   atan_t = 17'sd8;
      4'd12:   atan_t = 17'sd4;
      4'd13:   atan_t = 17'sd2;
      4'd14:   atan_t = 17'sd1;
      default: atan_t = 17'sd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      z_q       <= 17'sd0;
      sin_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      sin_neg_q <= sin_neg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    sin_neg_d = sin_neg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = 4'd0;
          z_d       = z_init;
          sin_neg_d = (a_clamp > 16'sd0);
        end
      end
      S_RUN: begin
        // inv is forced low on the load cycle, giving the fixed +atan(1) step.
        z_d = inv ? (z_q - atan_t) : (z_q + atan_t);
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    addr = 4'd0;
    load = 1'b0;
    inv  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN: begin
        addr = cnt_q;
        load = (cnt_q == 4'd0);
        inv  = (cnt_q != 4'd0) && !z_q[16];
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        addr = 4'd0;
      end
    endcase
  end

  assign sin_neg = sin_neg_q;

endmodule

`default_nettype wire

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 Parameter: ANGLE_MAX, 16'sd25736, clamp magnitude for the input angle (pi/2 in Q2.14).
REQ-002 clock  input  1  the only clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new sin/cos evaluation; sampled on rising clock.
REQ-005 angle  input  16  signed Q2.14 radians; sampled in the start-accepting cycle.
REQ-006 addr  output  4  iteration index (shift amount) to the rotation datapath.
REQ-007 load  output  1  datapath initialise strobe; that cycle is iteration 0.
REQ-008 inv  output  1  rotation direction to the datapath: 1 = positive, 0 = negative.
REQ-009 busy  output  1  high while an evaluation is in progress.
REQ-010 done  output  1  one-cycle pulse: datapath sin/cos valid from this cycle on.
REQ-011 sin_neg  output  1  downstream shall negate sin when high; stable from start acceptance until the next acceptance.

Function
REQ-012 States: IDLE, RUN, DONE.
- start accepted only in IDLE or DONE.
- Acceptance cycle: next state RUN, iteration counter cnt=0.
REQ-013 Angle clamping on acceptance:
- a = angle saturated to [-ANGLE_MAX, +ANGLE_MAX].
- -32768 maps to -25736.
REQ-014 On acceptance: sin_neg = (a > 0); residual z = -|a| (17-bit internal is acceptable).
- This reduces input to [-pi/2, 0]; sin(-x) = -sin(x), cos unchanged.
REQ-015 In RUN: addr = cnt and load = (cnt == 0).
- inv = 0 when cnt == 0.
- inv = ~z[sign] (1 when z >= 0) when cnt = 1..15.
- All three are decoded from registered state only; no combinational path from start or angle.
REQ-016 Residual update each RUN cycle, with T = atan ROM entry [cnt]:
- z <= z + T when inv = 0.
- z <= z - T when inv = 1.
- Load cycle is always treated as a forced negative rotation: z <= z + 12868.
REQ-017 atan ROM, Q2.14, index 0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.
REQ-018 cnt increments each RUN cycle; RUN lasts exactly 16 cycles (cnt 0..15).
- After cnt == 15: next state DONE; cnt does not wrap into a 17th iteration.
REQ-019 DONE lasts one cycle: done = 1, busy = 0, load = 0.
- Next state IDLE, or RUN if start is asserted (back-to-back).
REQ-020 Outside RUN: addr = 0, load = 0, inv = 0.
- busy = 1 exactly in RUN cycles.
REQ-021 start while in RUN is ignored: no restart, angle not resampled, sin_neg unchanged.
REQ-022 Latency: with start accepted in cycle t, load = 1 in t+1, done = 1 in t+17.

Reset
REQ-023 reset high at a rising edge forces, from the next cycle:
- state IDLE, cnt = 0, z = 0, sin_neg = 0;
- addr = 0, load = 0, inv = 0, busy = 0, done = 0.
REQ-024 reset overrides start in the same cycle.
- Reset mid-RUN aborts the evaluation with no done pulse.
REQ-025 The first start after reset release is accepted normally.

Verification
REQ-026 angle = 0, start one cycle:
- sin_neg = 0; cycle t+1: load = 1, addr = 0, inv = 0, z -> 12868.
- t+2: addr = 1, inv = 1, z -> 5272.
- done exactly at t+17.
REQ-027 angle = +12868 (pi/4):
- sin_neg = 1, z0 = -12868, z = 0 after the load cycle.
- cnt = 1: inv = 1, z -> -7596; cnt = 2: inv = 0, z -> -3582.
REQ-028 angle = +30000 -> clamp: sin_neg = 1, z0 = -25736.
- angle = -32768 -> clamp: sin_neg = 0, z0 = -25736.
- Both: identical addr/inv sequences over the 16 RUN cycles.
REQ-029 start pulsed again at cnt = 5 with a different angle:
- ignored; done at the original t+17; sin_neg unchanged.
REQ-030 reset asserted at cnt = 7:
- next cycle busy = 0, load = 0, addr = 0, and no done pulse.
- New start then yields load one cycle later.
REQ-031 start held high through the DONE cycle:
- load = 1 in the cycle after done.
- sin_neg updates from the new angle; busy = 1 again.
